uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte buffer and launch sequencer directly upstream of the UART transmitter.
- Accepts bytes from the CPU/peripheral bus over a valid/ready handshake and stores them in a DEPTH-entry FIFO.
- Issues single-cycle send strobes to the transmitter whenever it is idle, so software can queue a burst without polling the transmitter busy flag per byte.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, minimum 2.
- PAYLOAD_BITS, 8, data bits per UART packet; must match the transmitter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  PAYLOAD_BITS  byte to enqueue.
- in_valid  input  1  in_data valid this cycle.
- in_ready  output  1  FIFO can accept; a push occurs on in_valid && in_ready.
- flush  input  1  discard all queued bytes.
- uart_tx_en  output  1  one-cycle send strobe to the transmitter.
- uart_tx_data  output  PAYLOAD_BITS  byte presented with uart_tx_en.
- uart_tx_busy  input  1  transmitter busy flag.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- tx_idle  output  1  FIFO empty, FSM in IDLE, and uart_tx_busy low.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: in_ready=1, uart_tx_en=0, uart_tx_data=0, level=0, FSM=IDLE, pointers=0.
- A reset mid-transmission drops queued bytes. The transmitter is not affected.

FIFO:
- in_ready = (level != DEPTH), derived combinationally from the registered level.
- Push writes at wr_ptr. Pop reads at rd_ptr.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- Level is updated +1 on push only, -1 on pop only, and is unchanged on a simultaneous push and pop.
- Pushing while full is impossible, since in_ready is low.
- A simultaneous push and pop when level==1 is legal. The popped byte is the old head.

FSM (registered outputs):
- IDLE: if level!=0 and !uart_tx_busy, pop the head, load uart_tx_data, set uart_tx_en=1, and go to ARM.
- ARM: uart_tx_en=0. The transmitter has now sampled the strobe. Go to WAIT_BUSY.
- WAIT_BUSY: wait for uart_tx_busy=1, then go to WAIT_DONE.
  - If busy is not seen within 2 cycles, go to IDLE. This guards against a missed strobe.
- WAIT_DONE: when uart_tx_busy=0, go to IDLE.
- uart_tx_en is never high in two consecutive cycles.
- Minimum gap from busy falling to the next uart_tx_en is 1 cycle.
- Latency from a push into an empty FIFO with the transmitter idle: uart_tx_en is high 1 cycle after the push edge, and level returns to 0 on that same edge.
- uart_tx_data holds its value until the next launch.

Flush:
- flush=1 for one cycle sets level=0 and rd_ptr=wr_ptr.
- The byte already launched is unaffected and the FSM continues normally.
- flush has priority over a simultaneous push; that push is dropped.

Optional Feature:
- Macro: UART_TX_FIFO_CRLF_EN (requires PAYLOAD_BITS==8).
- With the macro defined:
  - When the head byte is 0x0A, IDLE launches 0x0D without popping and sets a cr_sent flag.
  - The next launch pops and sends 0x0A, then clears cr_sent.
  - flush and rst clear cr_sent.
  - level counts stored bytes only.
- Without the macro, bytes pass through unmodified and no cr_sent register exists.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state encoding (IDLE, ARM, WAIT_BUSY, WAIT_DONE; 2 bits);
  - the constants ASCII_CR=8'h0D and ASCII_LF=8'h0A;
  - the busy-timeout constant of 2.
- Sub-module sync_fifo: storage, pointers and level, with push, pop, flush, full and empty.
  - It is parameterised by DEPTH and WIDTH and reused later by the receive path.
- uart_tx_fifo instantiates sync_fifo and holds the FSM and the CRLF logic.

Test Plan:
- Single byte: push 0x55 into an empty FIFO with busy=0 → uart_tx_en pulses exactly 1 cycle later with uart_tx_data=0x55, and level=0.
- Burst: push 0x01..0x08 back-to-back with DEPTH=8 and the real uart_tx attached → in_ready falls after the 8th push (when the transmitter is stalled), and the serial output decodes 01..08 in order with no extra strobes.
- Full with simultaneous pop: hold busy=1 with level=8, release busy while pushing 0xAA → push refused while in_ready=0, then accepted the cycle after the pop, and level returns to 8.
- Flush: queue 0x10,0x20,0x30 with the first launched, then assert flush → only 0x10 is transmitted, level=0, and tx_idle=1 after busy falls.
- Missed-busy guard: tie busy=0 and push 0x11,0x22 → two strobes spaced exactly 4 cycles apart, with no lock-up.
- CRLF (macro defined): push 0x41,0x0A → transmitted sequence 0x41,0x0D,0x0A; without the macro → 0x41,0x0A.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART TX sequencer state encoding and character/timeout constants
package uart_pkg;
  typedef enum logic [1:0] {IDLE, ARM, WAIT_BUSY, WAIT_DONE} tx_state_e;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam int BUSY_TIMEOUT = 2;
endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo: power-of-two circular buffer with push, pop, flush and occupancy level
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] level_q;
  logic do_push, do_pop;
  assign full = level_q == (AW+1)'(DEPTH);
  assign empty = level_q == '0;
  assign level = level_q;
  assign rdata = mem_q[rd_q];
  assign do_push = push && !full && !flush;
  assign do_pop = pop && !empty && !flush;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else if (flush) begin
      rd_q <= wr_q;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      level_q <= level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wdata;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue that strobes the UART transmitter when idle; UART_TX_FIFO_CRLF_EN inserts CR before LF
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PAYLOAD_BITS-1:0]   in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      flush,
  output logic                      uart_tx_en,
  output logic [PAYLOAD_BITS-1:0]   uart_tx_data,
  input  logic                      uart_tx_busy,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      tx_idle
);
  tx_state_e state_q, state_d;
  logic en_q, en_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d, head;
  logic [1:0] cnt_q, cnt_d;
  logic full, empty, pop, launch, ins_cr;
  assign in_ready = !full;
  assign launch = state_q == IDLE && !empty && !uart_tx_busy && !flush;
  sync_fifo #(.DEPTH(DEPTH), .WIDTH(PAYLOAD_BITS)) u_fifo (
    .clk(clk), .rst(rst), .push(in_valid && in_ready), .pop(pop), .flush(flush),
    .wdata(in_data), .rdata(head), .full(full), .empty(empty), .level(level)
  );
`ifdef UART_TX_FIFO_CRLF_EN
  logic cr_q;
  assign ins_cr = head == PAYLOAD_BITS'(ASCII_LF) && !cr_q;
  always_ff @(posedge clk)
    if (rst || flush) cr_q <= 1'b0;
    else if (launch) cr_q <= ins_cr;
`else
  assign ins_cr = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    en_d = 1'b0;
    data_d = data_q;
    cnt_d = cnt_q;
    pop = 1'b0;
    case (state_q)
      IDLE: if (launch) begin
        pop = !ins_cr;
        en_d = 1'b1;
        data_d = ins_cr ? PAYLOAD_BITS'(ASCII_CR) : head;
        state_d = ARM;
      end
      ARM: begin
        cnt_d = '0;
        state_d = WAIT_BUSY;
      end
      // a strobe the transmitter never acknowledged must not wedge the queue
      WAIT_BUSY: if (uart_tx_busy) state_d = WAIT_DONE;
        else if (cnt_q == 2'(BUSY_TIMEOUT - 1)) state_d = IDLE;
        else cnt_d = cnt_q + 1'b1;
      WAIT_DONE: state_d = uart_tx_busy ? WAIT_DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      en_q <= 1'b0;
      data_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      en_q <= en_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
    end
  end
  assign uart_tx_en = en_q;
  assign uart_tx_data = data_q;
  assign tx_idle = empty && state_q == IDLE && !uart_tx_busy;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of queueing, launch timing, flush, busy guard and CRLF
module tb_uart_tx_fifo;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, busy_man = 1'b0, auto_tx = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, uart_tx_en, uart_tx_busy, tx_idle;
  logic [7:0] uart_tx_data;
  logic [3:0] level;
  int checks = 0, failures = 0, cyc = 0, mcnt = 0;
  logic [7:0] log_d [$];
  int log_c [$];

  uart_tx_fifo #(.DEPTH(8), .PAYLOAD_BITS(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data),
    .uart_tx_busy(uart_tx_busy), .level(level), .tx_idle(tx_idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // transmitter stand-in: busy for 6 cycles after sampling a strobe
  always @(posedge clk) mcnt <= !auto_tx ? 0 : uart_tx_en ? 6 : (mcnt != 0) ? mcnt - 1 : 0;
  assign uart_tx_busy = auto_tx ? (mcnt != 0) : busy_man;
  always @(negedge clk) if (uart_tx_en) begin log_d.push_back(uart_tx_data); log_c.push_back(cyc); end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] b);
    in_valid = 1'b1; in_data = b; step(); in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (tx_idle && level == 4'd0) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; repeat (3) step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (uart_tx_en !== 1'b0) begin failures++; $display("FAIL reset_tx_en got=%b exp=0", uart_tx_en); end
    checks++; if (uart_tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", uart_tx_data); end
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (tx_idle !== 1'b1) begin failures++; $display("FAIL reset_tx_idle got=%b exp=1", tx_idle); end
    rst = 1'b0; step();
  endtask

  task automatic test_single();
    int base = log_d.size();
    push(8'h55);
    checks++; if (level !== 4'd1) begin failures++; $display("FAIL single_level_push got=%0d exp=1", level); end
    checks++; if (uart_tx_en !== 1'b0) begin failures++; $display("FAIL single_en_early got=%b exp=0", uart_tx_en); end
    step();
    checks++; if (uart_tx_en !== 1'b1) begin failures++; $display("FAIL single_en got=%b exp=1", uart_tx_en); end
    checks++; if (uart_tx_data !== 8'h55) begin failures++; $display("FAIL single_data got=%h exp=55", uart_tx_data); end
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL single_level_pop got=%0d exp=0", level); end
    step();
    checks++; if (uart_tx_en !== 1'b0) begin failures++; $display("FAIL single_en_pulse got=%b exp=0", uart_tx_en); end
    checks++; if (uart_tx_data !== 8'h55) begin failures++; $display("FAIL single_data_hold got=%h exp=55", uart_tx_data); end
    repeat (6) step();
    checks++; if (tx_idle !== 1'b1) begin failures++; $display("FAIL single_idle got=%b exp=1", tx_idle); end
    checks++; if (log_d.size() - base !== 1) begin failures++; $display("FAIL single_count got=%0d exp=1", log_d.size() - base); end
  endtask

  task automatic test_missed_busy();
    int base = log_d.size();
    push(8'h11); push(8'h22);
    repeat (12) step();
    checks++; if (log_d.size() - base !== 2) begin failures++; $display("FAIL guard_count got=%0d exp=2", log_d.size() - base); end
    checks++; if (log_d[base] !== 8'h11) begin failures++; $display("FAIL guard_first got=%h exp=11", log_d[base]); end
    checks++; if (log_d[base+1] !== 8'h22) begin failures++; $display("FAIL guard_second got=%h exp=22", log_d[base+1]); end
    checks++; if (log_c[base+1] - log_c[base] !== 4) begin failures++; $display("FAIL guard_spacing got=%0d exp=4", log_c[base+1] - log_c[base]); end
    checks++; if (tx_idle !== 1'b1) begin failures++; $display("FAIL guard_idle got=%b exp=1", tx_idle); end
  endtask

  task automatic test_burst();
    int base = log_d.size();
    bit ok;
    int bad = 0;
    busy_man = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i));
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL burst_full_ready got=%b exp=0", in_ready); end
    checks++; if (level !== 4'd8) begin failures++; $display("FAIL burst_level got=%0d exp=8", level); end
    auto_tx = 1'b1;
    wait_idle(400, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL burst_timeout got=%b exp=1", ok); end
    checks++; if (log_d.size() - base !== 8) begin failures++; $display("FAIL burst_count got=%0d exp=8", log_d.size() - base); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (log_d[base+i] !== 8'(i + 1)) begin failures++; $display("FAIL burst_byte%0d got=%h exp=%h", i, log_d[base+i], 8'(i + 1)); end
    end
    for (int i = 1; i < 8; i++) if (log_c[base+i] - log_c[base+i-1] < 2) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL burst_adjacent_strobes got=%0d exp=0", bad); end
    auto_tx = 1'b0; busy_man = 1'b0; step();
  endtask

  task automatic test_full_pop();
    int base = log_d.size();
    bit ok;
    busy_man = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(8'h80 + i));
    checks++; if (level !== 4'd8) begin failures++; $display("FAIL fullpop_level_full got=%0d exp=8", level); end
    in_valid = 1'b1; in_data = 8'hAA; busy_man = 1'b0;
    step();
    busy_man = 1'b1;
    checks++; if (level !== 4'd7) begin failures++; $display("FAIL fullpop_refused got=%0d exp=7", level); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fullpop_ready got=%b exp=1", in_ready); end
    checks++; if (uart_tx_en !== 1'b1 || uart_tx_data !== 8'h80) begin failures++; $display("FAIL fullpop_launch got=%b/%h exp=1/80", uart_tx_en, uart_tx_data); end
    step();
    in_valid = 1'b0;
    checks++; if (level !== 4'd8) begin failures++; $display("FAIL fullpop_level_refill got=%0d exp=8", level); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fullpop_ready_low got=%b exp=0", in_ready); end
    auto_tx = 1'b1;
    wait_idle(400, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL fullpop_timeout got=%b exp=1", ok); end
    checks++; if (log_d.size() - base !== 9) begin failures++; $display("FAIL fullpop_count got=%0d exp=9", log_d.size() - base); end
    checks++; if (log_d[base+7] !== 8'h87) begin failures++; $display("FAIL fullpop_byte7 got=%h exp=87", log_d[base+7]); end
    checks++; if (log_d[base+8] !== 8'hAA) begin failures++; $display("FAIL fullpop_last got=%h exp=AA", log_d[base+8]); end
    auto_tx = 1'b0; busy_man = 1'b0; step();
  endtask

  task automatic test_flush();
    int base = log_d.size();
    bit ok;
    auto_tx = 1'b1;
    push(8'h10); push(8'h20); push(8'h30);
    checks++; if (level !== 4'd2) begin failures++; $display("FAIL flush_level_pre got=%0d exp=2", level); end
    flush = 1'b1; step(); flush = 1'b0;
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL flush_level got=%0d exp=0", level); end
    checks++; if (tx_idle !== 1'b0) begin failures++; $display("FAIL flush_busy_idle got=%b exp=0", tx_idle); end
    wait_idle(100, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL flush_timeout got=%b exp=1", ok); end
    repeat (10) step();
    checks++; if (log_d.size() - base !== 1) begin failures++; $display("FAIL flush_count got=%0d exp=1", log_d.size() - base); end
    checks++; if (log_d[base] !== 8'h10) begin failures++; $display("FAIL flush_byte got=%h exp=10", log_d[base]); end
    checks++; if (tx_idle !== 1'b1) begin failures++; $display("FAIL flush_idle got=%b exp=1", tx_idle); end
    auto_tx = 1'b0; step();
  endtask

  task automatic test_crlf();
    int base = log_d.size();
    bit ok;
    logic [7:0] exp_q [$];
`ifdef UART_TX_FIFO_CRLF_EN
    exp_q = '{8'h41, 8'h0D, 8'h0A};
`else
    exp_q = '{8'h41, 8'h0A};
`endif
    auto_tx = 1'b1;
    push(8'h41); push(8'h0A);
    wait_idle(200, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL crlf_timeout got=%b exp=1", ok); end
    checks++; if (log_d.size() - base !== exp_q.size()) begin failures++; $display("FAIL crlf_count got=%0d exp=%0d", log_d.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (log_d[base+i] !== exp_q[i]) begin failures++; $display("FAIL crlf_byte%0d got=%h exp=%h", i, log_d[base+i], exp_q[i]); end
    end
    auto_tx = 1'b0; step();
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_missed_busy();
    test_burst();
    test_full_pop();
    test_flush();
    test_crlf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
